pw_qual_arbiter: RTL

PW_QUAL_ARBITER -- requirements
Module: pw_qual_arbiter

---
 rtl/pw_qual_arbiter.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pw_qual_arbiter.sv
// pw_qual_arbiter: per-channel pulse-width qualifier feeding a round-robin
// grant FSM (IDLE -> GRANT -> RELEASE -> IDLE) with a minimum hold time.
// Optional feature macro: PWQA_TIMEOUT_EN. When it is defined, a grant held for
// MAX_HOLD cycles is revoked if another channel is waiting.
module pw_qual_arbiter #(
    parameter int N_CH         = 4,
    parameter int CNT_W        = 8,
    parameter int DEF_ASSERT   = 2,
    parameter int DEF_DEASSERT = 2,
    parameter int MIN_HOLD     = 4,
    parameter int MAX_HOLD     = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_CH-1:0]          req_i,
    input  logic                     cfg_we,
    input  logic [$clog2(N_CH)-1:0]  cfg_ch,
    input  logic [CNT_W-1:0]         cfg_assert,
    input  logic [CNT_W-1:0]         cfg_deassert,
    output logic [N_CH-1:0]          qual_o,
    output logic [N_CH-1:0]          grant_o,
    output logic                     busy_o
);

    localparam int IDX_W = $clog2(N_CH);
    localparam logic [CNT_W:0] ONE_X = (CNT_W+1)'(1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } state_t;

    // Qualifier storage
    logic [CNT_W-1:0] th_a   [N_CH];
    logic [CNT_W-1:0] th_d   [N_CH];
    logic [CNT_W-1:0] hi_cnt [N_CH];
    logic [CNT_W-1:0] lo_cnt [N_CH];
    logic [CNT_W:0]   eff_a  [N_CH];
    logic [CNT_W:0]   eff_d  [N_CH];
    logic [CNT_W:0]   hi_inc [N_CH];
    logic [CNT_W:0]   lo_inc [N_CH];
    logic [N_CH-1:0]  qual_q;

    // Arbiter storage
    state_t            state_q, state_d;
    logic [N_CH-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  last_q, last_d;
    logic [CNT_W-1:0]  hold_q, hold_d;
    logic              pick_valid;
    logic [IDX_W-1:0]  pick_idx;
    int                cand;
    logic              min_met;
    logic              owner_drop;
    logic              timeout_hit;
    logic              release_now;

    assign qual_o  = qual_q;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    // Effective thresholds (zero behaves as one) and next run-counter values
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            eff_a[i]  = (th_a[i] == '0) ? ONE_X : {1'b0, th_a[i]};
            eff_d[i]  = (th_d[i] == '0) ? ONE_X : {1'b0, th_d[i]};
            hi_inc[i] = {1'b0, hi_cnt[i]} + ONE_X;
            lo_inc[i] = {1'b0, lo_cnt[i]} + ONE_X;
        end
    end

    // Per-channel run counters, thresholds and qualified level
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                th_a[i]   <= CNT_W'(DEF_ASSERT);
                th_d[i]   <= CNT_W'(DEF_DEASSERT);
                hi_cnt[i] <= '0;
                lo_cnt[i] <= '0;
            end
            qual_q <= '0;
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_we && (int'(cfg_ch) == i)) begin
                    th_a[i]   <= cfg_assert;
                    th_d[i]   <= cfg_deassert;
                    hi_cnt[i] <= '0;
                    lo_cnt[i] <= '0;
                end else if (req_i[i]) begin
                    lo_cnt[i] <= '0;
                    if (hi_inc[i] >= eff_a[i]) begin
                        hi_cnt[i] <= eff_a[i][CNT_W-1:0];
                        qual_q[i] <= 1'b1;
                    end else begin
                        hi_cnt[i] <= hi_inc[i][CNT_W-1:0];
                    end
                end else begin
                    hi_cnt[i] <= '0;
                    if (lo_inc[i] >= eff_d[i]) begin
                        lo_cnt[i] <= eff_d[i][CNT_W-1:0];
                        qual_q[i] <= 1'b0;
                    end else begin
                        lo_cnt[i] <= lo_inc[i][CNT_W-1:0];
                    end
                end
            end
        end
    end

    // Round-robin search for the first qualified channel after last_grant
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= N_CH; k++) begin
            cand = int'(last_q) + k;
            if (cand >= N_CH) begin
                cand = cand - N_CH;
            end
            if (!pick_valid && qual_q[IDX_W'(cand)]) begin
                pick_valid = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Release decision for the current owner
    always_comb begin
        min_met     = (int'(hold_q) >= MIN_HOLD);
        owner_drop  = min_met && !qual_q[owner_q];
        timeout_hit = 1'b0;
`ifdef PWQA_TIMEOUT_EN
        timeout_hit = (int'(hold_q) >= MAX_HOLD) && (|(qual_q & ~grant_q));
`else
        timeout_hit = 1'b0;
`endif
        release_now = owner_drop || timeout_hit;
    end

    // FSM next-state and next-output logic
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        owner_d = owner_q;
        last_d  = last_q;
        hold_d  = hold_q;
        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_valid) begin
                    state_d           = GRANT;
                    grant_d[pick_idx] = 1'b1;
                    owner_d           = pick_idx;
                    hold_d            = CNT_W'(1);
                end
            end
            GRANT: begin
                if (hold_q != '1) begin
                    hold_d = hold_q + CNT_W'(1);
                end
                if (release_now) begin
                    state_d = RELEASE;
                    grant_d = '0;
                    last_d  = owner_q;
                end
            end
            RELEASE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            default: begin
                grant_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    // FSM state register; reset drops any grant on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            last_q  <= IDX_W'(N_CH - 1);
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            hold_q  <= hold_d;
        end
    end

endmodule
